mma_result_serializer: RTL and testbench
========================================

MMA_RESULT_SERIALIZER -- requirements
Module: mma_result_serializer

Interface
REQ-001 Parameter M, default 8: rows of result matrix D; SHALL be >= 1.
REQ-002 Parameter N, default 4: columns of result matrix D; SHALL be >= 1.
REQ-003 Parameter LANES, default 4: 32-bit elements per output beat; M*N SHALL be a multiple of LANES (elaboration error otherwise).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 d_i  input  signed 32 x [M][N]  result matrix from the MMA output buffer.
REQ-007 d_valid_i  input  1  d_i valid.
REQ-008 d_ready_o  output  1  serializer can accept d_i.
REQ-009 pack16_i  input  1  request 16-bit packed output for the matrix being accepted.
REQ-010 data_o  output  32 x [LANES]  current output beat, lane 0 = lowest element index.
REQ-011 valid_o  output  1  data_o valid.
REQ-012 ready_i  input  1  downstream accepts data_o.
REQ-013 last_o  output  1  current beat is final beat of the matrix.
REQ-014 beat_o  output  clog2(M*N/LANES) (min 1)  index of current beat, 0-based.

Function
REQ-015 Handshakes: a transfer occurs on a cycle where valid and ready are both high; valid SHALL NOT depend combinationally on the corresponding ready.
REQ-016 States: IDLE (no matrix held) and SEND (matrix held in internal register, beats pending).
REQ-017 IDLE: d_ready_o = 1; on d_valid_i, capture d_i and pack16_i into registers, beat counter = 0, go SEND.
REQ-018 SEND: valid_o = 1; beat counter increments on each output transfer; data_o, last_o, beat_o SHALL stay stable while valid_o && !ready_i.
REQ-019 Element order is row-major: element e = D[e / N][e % N].
REQ-020 Unpacked mode: beats B = M*N/LANES; lane l of beat b = element b*LANES + l, unmodified.
REQ-021 last_o = 1 exactly when beat counter = B-1 (or B/2-1 in packed mode); in SEND only, else 0.
REQ-022 Final-beat transfer: if d_valid_i also high in that cycle, new matrix SHALL be captured and next cycle is SEND with beat 0 (zero-bubble); otherwise go IDLE.
REQ-023 d_ready_o in SEND = ready_i && last_o (combinational pass-through of ready only; valid paths registered).
REQ-024 Latency: first beat valid_o one cycle after input transfer; steady-state throughput one beat per cycle with ready_i held high, including back-to-back matrices.
REQ-025 d_i changes while not accepted SHALL have no effect on held data.

Reset
REQ-026 While rst_i high at a clock edge: state = IDLE, beat counter = 0, valid_o = 0, last_o = 0, beat_o = 0, held data = 0, held pack flag = 0.
REQ-027 d_ready_o SHALL be 0 while rst_i is high; 1 in the first cycle after rst_i falls.
REQ-028 Reset mid-matrix SHALL discard remaining beats; no further beat of that matrix is emitted.

Configuration
REQ-029 Macro MMA_SER_PACK16_EN selects packed-output support.
REQ-030 Defined: when held pack flag = 1, beats = B/2 (M*N SHALL be a multiple of 2*LANES); lane l of beat b = {sat16(element 2k+1), sat16(element 2k)}, k = b*LANES + l; sat16 clamps to [-32768, 32767], then takes low 16 bits.
REQ-031 Not defined: pack16_i ignored, no saturation logic present, always unpacked behaviour of REQ-020.

Verification (M=2, N=2, LANES=2 unless stated)
REQ-032 Reset: rst_i high 3 cycles with d_valid_i=1 -> valid_o=0, d_ready_o=0 throughout; d_ready_o=1 first cycle after release.
REQ-033 Basic: D={{1,2},{3,4}}, ready_i=1 -> beats {1,2} (beat_o=0,last_o=0) then {3,4} (beat_o=1,last_o=1); d_ready_o=1 on second beat.
REQ-034 Backpressure: ready_i=0 for 5 cycles on beat 0 -> data_o={1,2} stable, valid_o=1, d_ready_o=0; beat 1 follows ready_i rise.
REQ-035 Back-to-back: two matrices {{1,2},{3,4}}, {{5,6},{7,8}}, d_valid_i and ready_i held high -> 4 consecutive beats {1,2},{3,4},{5,6},{7,8}, no bubble.
REQ-036 Packed (MMA_SER_PACK16_EN, LANES=1): D={{70000,-5},{-70000,3}}, pack16_i=1 -> beat0=0xFFFB7FFF, beat1=0x00038000, last_o on beat1.
REQ-037 Mid-matrix reset: assert rst_i after beat 0 transfer -> beat 1 never appears; next matrix starts at beat_o=0.

Source files
------------

// File: rtl/mma_result_serializer.sv
// ---------------------------------------------------------------------------
// mma_result_serializer
//
// Takes one complete M x N result matrix (32-bit signed elements) from the
// MMA output buffer and streams it out as beats of LANES 32-bit words in
// row-major order (element e = D[e / N][e % N], lane 0 = lowest index).
// The matrix is held in an internal register, so the upstream buffer is free
// as soon as d_i is accepted. A new matrix can be accepted in the same cycle
// as the final beat transfers, which gives zero-bubble back-to-back output.
//
// Optional feature (compile-time macro MMA_SER_PACK16_EN):
//   When defined, pack16_i (sampled with the matrix) selects 16-bit packed
//   output: each 32-bit lane carries two saturated 16-bit elements, so the
//   matrix takes half as many beats. When undefined, pack16_i is ignored and
//   no saturation logic is built.
//
// Ports:
//   clk_i      sole clock, rising edge
//   rst_i      synchronous active-high reset
//   d_i        flattened matrix, element e at d_i[32*e +: 32]
//   d_valid_i  d_i valid
//   d_ready_o  serializer can accept d_i
//   pack16_i   request packed output for the matrix being accepted
//   data_o     current beat, lane l at data_o[32*l +: 32]
//   valid_o    data_o valid
//   ready_i    downstream accepts data_o
//   last_o     current beat is the final beat of the matrix
//   beat_o     0-based index of the current beat
// ---------------------------------------------------------------------------
module mma_result_serializer #(
   parameter int M     = 8,
   parameter int N     = 4,
   parameter int LANES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [M*N*32-1:0]      d_i,
   input  logic                   d_valid_i,
   output logic                   d_ready_o,
   input  logic                   pack16_i,
   output logic [LANES*32-1:0]    data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   last_o,
   output logic [(((M*N/LANES) > 1) ? $clog2(M*N/LANES) : 1)-1:0] beat_o
);

   localparam int NB     = M * N / LANES;
   localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BEAT_W-1:0] LAST_U = BEAT_W'(NB - 1);

   // Elaboration-time parameter checks
   generate
      if (M < 1 || N < 1 || LANES < 1) begin : g_bad_dims
         $error("mma_result_serializer: M, N and LANES must all be >= 1");
      end
      if ((M * N) % LANES != 0) begin : g_bad_lanes
         $error("mma_result_serializer: M*N must be a multiple of LANES");
      end
`ifdef MMA_SER_PACK16_EN
      if ((M * N) % (2 * LANES) != 0) begin : g_bad_pack
         $error("mma_result_serializer: M*N must be a multiple of 2*LANES for packed output");
      end
`endif
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_nxt;
   logic [BEAT_W-1:0]   beat_q, beat_nxt;
   logic [M*N*32-1:0]   d_q;
   logic                load;
   logic [BEAT_W-1:0]   last_idx;

`ifdef MMA_SER_PACK16_EN
   localparam logic [BEAT_W-1:0] LAST_P = BEAT_W'(NB / 2 - 1);

   logic pack_q;

   // Clamp to the signed 16-bit range, keep the low half.
   function automatic logic [15:0] sat16(input logic signed [31:0] x);
      if (x > 32'sd32767)
         return 16'h7FFF;
      else if (x < -32'sd32768)
         return 16'h8000;
      else
         return x[15:0];
   endfunction

   assign last_idx = pack_q ? LAST_P : LAST_U;
`else
   logic unused_pack16;
   assign unused_pack16 = pack16_i;
   assign last_idx      = LAST_U;
`endif

   // Outputs are decoded from registered state only, so valid_o, data_o,
   // last_o and beat_o hold steady during backpressure.
   assign valid_o = (state_q == SEND);
   assign last_o  = (state_q == SEND) && (beat_q == last_idx);
   assign beat_o  = beat_q;

   // Lane selection from the held matrix
   always_comb begin
      data_o = '0;
      for (int l = 0; l < LANES; l++) begin
`ifdef MMA_SER_PACK16_EN
         if (pack_q) begin
            int k;
            k = int'(beat_q) * LANES + l;
            data_o[32*l +: 32] = {sat16(d_q[32*(2*k+1) +: 32]),
                                  sat16(d_q[32*(2*k)   +: 32])};
         end else begin
            data_o[32*l +: 32] = d_q[32*(int'(beat_q) * LANES + l) +: 32];
         end
`else
         data_o[32*l +: 32] = d_q[32*(int'(beat_q) * LANES + l) +: 32];
`endif
      end
   end

   // Next-state and input-side handshake
   always_comb begin
      state_nxt = state_q;
      beat_nxt  = beat_q;
      load      = 1'b0;
      d_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            d_ready_o = 1'b1;
            if (d_valid_i) begin
               load      = 1'b1;
               beat_nxt  = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            // Only ready passes through combinationally; last_o is registered.
            d_ready_o = ready_i && last_o;
            if (ready_i) begin
               if (last_o) begin
                  beat_nxt = '0;
                  if (d_valid_i) begin
                     load      = 1'b1;
                     state_nxt = SEND;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  beat_nxt = beat_q + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
         end
      endcase
      if (rst_i) begin
         d_ready_o = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_nxt;
         beat_q  <= beat_nxt;
      end
   end

   // Held matrix (cleared on reset so no stale data survives)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_q <= '0;
      end else if (load) begin
         d_q <= d_i;
      end
   end

`ifdef MMA_SER_PACK16_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pack_q <= 1'b0;
      end else if (load) begin
         pack_q <= pack16_i;
      end
   end
`endif

endmodule

// File: tb/tb_mma_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_mma_result_serializer
//
// Directed bench for mma_result_serializer with M=2, N=2, LANES=2. Inputs
// are driven on the falling edge; outputs are sampled 1 time unit later.
// When MMA_SER_PACK16_EN is defined a second instance (LANES=1) exercises
// the packed, saturating output.
// ---------------------------------------------------------------------------
module tb_mma_result_serializer;

   logic          clk = 1'b0;
   logic          rst;
   logic [127:0]  d;
   logic          d_valid;
   logic          d_ready;
   logic          pack16;
   logic [63:0]   data;
   logic          valid;
   logic          ready;
   logic          last;
   logic [0:0]    beat;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mma_result_serializer #(.M(2), .N(2), .LANES(2)) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .d_i       (d),
      .d_valid_i (d_valid),
      .d_ready_o (d_ready),
      .pack16_i  (pack16),
      .data_o    (data),
      .valid_o   (valid),
      .ready_i   (ready),
      .last_o    (last),
      .beat_o    (beat)
   );

`ifdef MMA_SER_PACK16_EN
   logic          pk_d_valid;
   logic          pk_d_ready;
   logic [31:0]   pk_data;
   logic          pk_valid;
   logic          pk_last;
   logic [1:0]    pk_beat;

   mma_result_serializer #(.M(2), .N(2), .LANES(1)) u_dut_pk (
      .clk_i     (clk),
      .rst_i     (rst),
      .d_i       (d),
      .d_valid_i (pk_d_valid),
      .d_ready_o (pk_d_ready),
      .pack16_i  (pack16),
      .data_o    (pk_data),
      .valid_o   (pk_valid),
      .ready_i   (ready),
      .last_o    (pk_last),
      .beat_o    (pk_beat)
   );
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mat(input int a, input int b, input int c, input int e);
      return {32'(e), 32'(c), 32'(b), 32'(a)};
   endfunction

   // Check a visible beat of the main instance
   task automatic chk_beat(input string tag, input logic [63:0] exp_data,
                           input logic exp_beat, input logic exp_last, input logic exp_dr);
      check({tag, ".valid"}, 64'(valid), 64'd1);
      check({tag, ".data"},  data, exp_data);
      check({tag, ".beat"},  64'(beat), 64'(exp_beat));
      check({tag, ".last"},  64'(last), 64'(exp_last));
      check({tag, ".dready"}, 64'(d_ready), 64'(exp_dr));
   endtask

   localparam logic [63:0] B12 = 64'h00000002_00000001;
   localparam logic [63:0] B34 = 64'h00000004_00000003;
   localparam logic [63:0] B56 = 64'h00000006_00000005;
   localparam logic [63:0] B78 = 64'h00000008_00000007;

   initial begin
      rst     = 1'b1;
      d       = mat(1, 2, 3, 4);
      d_valid = 1'b1;
      pack16  = 1'b0;
      ready   = 1'b1;
`ifdef MMA_SER_PACK16_EN
      pk_d_valid = 1'b0;
`endif

      // Reset held for 3 cycles with d_valid high
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check("rst.valid",  64'(valid),   64'd0);
         check("rst.dready", 64'(d_ready), 64'd0);
         check("rst.last",   64'(last),    64'd0);
         check("rst.beat",   64'(beat),    64'd0);
      end
      rst     = 1'b0;
      d_valid = 1'b0;
      #1;
      check("rel.dready", 64'(d_ready), 64'd1);
      check("rel.valid",  64'(valid),   64'd0);

      // Basic
      @(negedge clk);
      d       = mat(1, 2, 3, 4);
      d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      #1 chk_beat("basic.b0", B12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat("basic.b1", B34, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1 check("basic.idle", 64'(valid), 64'd0);

      // Backpressure; d_i changes while not accepted
      @(negedge clk);
      d       = mat(1, 2, 3, 4);
      d_valid = 1'b1;
      ready   = 1'b0;
      @(negedge clk);
      d_valid = 1'b0;
      d       = mat(9, 9, 9, 9);
      for (int i = 0; i < 5; i++) begin
         #1 chk_beat("bp.hold", B12, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      ready = 1'b1;
      #1 chk_beat("bp.rel", B12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat("bp.b1", B34, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1 check("bp.idle", 64'(valid), 64'd0);

      // Back-to-back
      d       = mat(1, 2, 3, 4);
      d_valid = 1'b1;
      @(negedge clk);
      d = mat(5, 6, 7, 8);
      #1 chk_beat("b2b.b0", B12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat("b2b.b1", B34, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      d_valid = 1'b0;
      #1 chk_beat("b2b.b2", B56, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat("b2b.b3", B78, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1 check("b2b.idle", 64'(valid), 64'd0);

      // Mid-matrix reset after beat 0 transfers
      d       = mat(1, 2, 3, 4);
      d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      #1 chk_beat("mid.b0", B12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst   = 1'b1;
      ready = 1'b0;
      #1 check("mid.rst.dready", 64'(d_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("mid.rst.valid", 64'(valid), 64'd0);
      ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1 check("mid.gone", 64'(valid), 64'd0);
      end
      d       = mat(5, 6, 7, 8);
      d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
      #1 chk_beat("mid.next.b0", B56, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat("mid.next.b1", B78, 1'b1, 1'b1, 1'b1);
      @(negedge clk);

`ifdef MMA_SER_PACK16_EN
      // Packed, saturating output on the LANES=1 instance
      d          = mat(70000, -5, -70000, 3);
      pack16     = 1'b1;
      pk_d_valid = 1'b1;
      check("pk.dready", 64'(pk_d_ready), 64'd1);
      @(negedge clk);
      pk_d_valid = 1'b0;
      pack16     = 1'b0;
      #1;
      check("pk.b0.valid", 64'(pk_valid), 64'd1);
      check("pk.b0.data",  64'(pk_data),  64'h00000000_FFFB7FFF);
      check("pk.b0.beat",  64'(pk_beat),  64'd0);
      check("pk.b0.last",  64'(pk_last),  64'd0);
      @(negedge clk);
      #1;
      check("pk.b1.data",  64'(pk_data),  64'h00000000_00038000);
      check("pk.b1.beat",  64'(pk_beat),  64'd1);
      check("pk.b1.last",  64'(pk_last),  64'd1);
      @(negedge clk);
      #1 check("pk.idle", 64'(pk_valid), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
